t_ff_bank: RTL and testbench
============================

# t_ff_bank

Parametrised bank of WIDTH toggle flip-flops: the multi-bit, multi-mode successor to the single-bit T flip-flop. Each cycle the bank holds, toggles per-bit under a T mask, counts as a synchronous binary counter, or parallel-loads. It also produces a wrap pulse and a saturating change counter. It sits wherever the design needs divided enables, toggle-status registers or small event counters.

## Interface
- WIDTH, 4, number of T flip-flops (≥1)
- RST_VAL, 0, value of q after reset (WIDTH bits)
- CNT_W, 8, width of change counter chg_cnt (≥1)
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  reset, synchronous, active-low
- en  input  1  global enable; 0 = hold all state
- mode  input  2  operation select: HOLD / TOGGLE / COUNT / LOAD
- t  input  WIDTH  per-bit toggle mask (TOGGLE); t[0] = count enable (COUNT)
- d  input  WIDTH  parallel load data (LOAD)
- q  output  WIDTH  flip-flop state
- wrap  output  1  one-cycle pulse: COUNT rolled over from all-ones to 0
- chg  output  1  registered flag: q changed at the last posedge
- chg_cnt  output  CNT_W  saturating count of posedges at which q changed

## Operation
- Reset (rst_n=0 at posedge): q=RST_VAL, wrap=0, chg=0, chg_cnt=0. Reset overrides en and mode.
- en=0: q and chg_cnt hold; wrap=0, chg=0.
- en=1 behaviour per mode:
  - HOLD (2'b00): q holds.
  - TOGGLE (2'b01): q <= q ^ t. Bits with t[i]=0 hold.
  - COUNT (2'b10): if t[0]=1, q <= q+1 modulo 2^WIDTH; t[WIDTH-1:1] ignored. If t[0]=0, hold.
  - LOAD (2'b11): q <= d.
- wrap <= (en && mode==COUNT && t[0] && q=={WIDTH{1'b1}}).
- chg <= (next q != q). A LOAD of the value already in q, or a TOGGLE with t=0, gives chg=0.
- chg_cnt increments when the next q != q and saturates at 2^CNT_W-1. It never wraps. It clears only on reset.
- WIDTH=1: COUNT and TOGGLE with t=1 behave identically (q inverts); wrap pulses on each 1→0 transition in COUNT.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Latency: inputs sampled at posedge N appear on q/wrap/chg/chg_cnt after posedge N.
- wrap and chg are single-cycle pulses aligned with the q update that caused them.
- A mode change takes effect at the next posedge, with no pipeline bubble and no dead cycle.
- Reset asserted mid-operation (e.g. mid-count) takes effect at the next posedge. The in-flight update is discarded and no wrap or chg pulse is emitted for it.
- When reset is released, the first active update occurs at the first posedge where rst_n=1.
- Inputs must be stable around posedge. The bank itself has no handshake; en is the only qualifier.

## Structure
- Shared package t_ff_pkg: typedef enum logic [1:0] mode_e {MODE_HOLD=2'b00, MODE_TOGGLE=2'b01, MODE_COUNT=2'b10, MODE_LOAD=2'b11}.
- Next-state logic is one combinational block computing q_nxt and wrap_nxt.
- Sub-module sat_counter (parameter W; inputs clk, rst_n, inc; output cnt) implements chg_cnt and is reusable elsewhere.

## Test plan
All scenarios use WIDTH=4, RST_VAL=0, CNT_W=3.
- Reset: hold rst_n=0 for 2 posedges with en=1, mode=LOAD, d=4'hF → q=0, wrap=0, chg=0, chg_cnt=0 throughout.
- TOGGLE: start from q=0; apply t=4'b0101 for 3 cycles → q goes 0101, 0000, 0101; chg=1 each cycle; chg_cnt=3. Then t=0 → q holds and chg=0.
- COUNT wrap: LOAD d=4'hE, then COUNT with t[0]=1 → q goes E, F, 0, 1. wrap=1 only in the cycle q becomes 0. Repeat with t=4'b1110 → q holds.
- en/HOLD: while counting, drop en for 3 cycles → q frozen and chg=0. Raise en → counting resumes from the frozen value. mode=HOLD with en=1 gives the same result.
- chg_cnt saturation: TOGGLE with t=4'b0001 for 10 cycles → chg_cnt sticks at 7. A LOAD of the current q gives chg=0 and no increment.
- Mid-operation reset: during COUNT at q=4'hF, assert rst_n=0 for 1 cycle → q=0 and wrap stays 0. Release rst_n → count restarts at 1 on the next posedge.

Source files
------------

// File: rtl/t_ff_pkg.sv
// Shared types for the T flip-flop bank: operation-select encoding.
package t_ff_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_COUNT  = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: one registered increment per inc cycle, sticks at all-ones.
// Latency 1 cycle; no backpressure, clears only on synchronous reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/t_ff_bank.sv
// Multi-mode T flip-flop bank (hold/toggle/count/load) with wrap pulse and change counter.
// All outputs registered, 1-cycle latency; no handshake, en is the only qualifier.
module t_ff_bank
  import t_ff_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             chg,
  output logic [CNT_W-1:0] chg_cnt
);

  mode_e            mode_s;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_q;
  logic             wrap_nxt;
  logic             chg_q;
  logic             chg_nxt;

  assign mode_s = mode_e'(mode);

  always_comb begin
    q_nxt    = q_q;
    wrap_nxt = 1'b0;
    if (en) begin
      unique case (mode_s)
        MODE_HOLD:   q_nxt = q_q;
        MODE_TOGGLE: q_nxt = q_q ^ t;
        MODE_COUNT: begin
          // Only t[0] qualifies counting; upper mask bits are don't-care here.
          if (t[0]) begin
            q_nxt    = q_q + WIDTH'(1);
            wrap_nxt = (q_q == {WIDTH{1'b1}});
          end
        end
        MODE_LOAD:   q_nxt = d;
        default:     q_nxt = q_q;
      endcase
    end
  end

  assign chg_nxt = (q_nxt != q_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q    <= RST_VAL;
      wrap_q <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      q_q    <= q_nxt;
      wrap_q <= wrap_nxt;
      chg_q  <= chg_nxt;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_chg_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (chg_nxt),
    .cnt  (chg_cnt)
  );

  assign q    = q_q;
  assign wrap = wrap_q;
  assign chg  = chg_q;

endmodule

// File: tb/tb_t_ff_bank.sv
// Randomised and directed bench for t_ff_bank against an arithmetic reference model.
module tb_t_ff_bank;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;
  localparam int QMOD  = 1 << WIDTH;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             wrap;
  logic             chg;
  logic [CNT_W-1:0] chg_cnt;

  int checks   = 0;
  int failures = 0;

  int m_q     = 0;
  int m_wrap  = 0;
  int m_chg   = 0;
  int m_cnt   = 0;
  bit m_valid = 0;

  t_ff_bank #(
    .WIDTH  (WIDTH),
    .RST_VAL(4'h0),
    .CNT_W  (CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .t      (t),
    .d      (d),
    .q      (q),
    .wrap   (wrap),
    .chg    (chg),
    .chg_cnt(chg_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the mode rules.
  always @(posedge clk) begin
    int nq;
    int w;
    if (!rst_n) begin
      m_q = 0; m_wrap = 0; m_chg = 0; m_cnt = 0;
    end else begin
      nq = m_q;
      w  = 0;
      if (en) begin
        case (mode)
          2'd1: nq = m_q ^ int'(t);
          2'd2: if (t[0]) begin
                  nq = (m_q + 1) % QMOD;
                  w  = (m_q == QMOD - 1) ? 1 : 0;
                end
          2'd3: nq = int'(d);
          default: nq = m_q;
        endcase
      end
      m_chg = (nq != m_q) ? 1 : 0;
      if (m_chg == 1 && m_cnt < CMAX) m_cnt = m_cnt + 1;
      m_q    = nq;
      m_wrap = w;
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_q",       int'(q),       m_q);
      chk("model_wrap",    int'(wrap),    m_wrap);
      chk("model_chg",     int'(chg),     m_chg);
      chk("model_chg_cnt", int'(chg_cnt), m_cnt);
    end
  end

  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [3:0] tt, input logic [3:0] dd);
    rst_n = r; en = e; mode = m; t = tt; d = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input int eq, input int ew,
                            input int ec, input int en_cnt);
    chk({nm, "_q"},   int'(q),       eq);
    chk({nm, "_wrap"}, int'(wrap),   ew);
    chk({nm, "_chg"}, int'(chg),     ec);
    chk({nm, "_cnt"}, int'(chg_cnt), en_cnt);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 2'd3; t = '0; d = 4'hF;

    // Reset overrides a pending LOAD of F.
    step(0, 1, 2'd3, 4'h0, 4'hF); expect_out("rst0", 0, 0, 0, 0);
    step(0, 1, 2'd3, 4'h0, 4'hF); expect_out("rst1", 0, 0, 0, 0);
    step(1, 1, 2'd0, 4'h0, 4'h0); expect_out("hold0", 0, 0, 0, 0);

    step(1, 1, 2'd1, 4'h5, 4'h0); expect_out("tog1", 5, 0, 1, 1);
    step(1, 1, 2'd1, 4'h5, 4'h0); expect_out("tog2", 0, 0, 1, 2);
    step(1, 1, 2'd1, 4'h5, 4'h0); expect_out("tog3", 5, 0, 1, 3);
    step(1, 1, 2'd1, 4'h0, 4'h0); expect_out("tog0", 5, 0, 0, 3);

    step(1, 1, 2'd3, 4'h0, 4'hE); expect_out("loadE", 14, 0, 1, 4);
    step(1, 1, 2'd2, 4'h1, 4'h0); expect_out("cntF", 15, 0, 1, 5);
    step(1, 1, 2'd2, 4'h1, 4'h0); expect_out("cnt0", 0, 1, 1, 6);
    step(1, 1, 2'd2, 4'h1, 4'h0); expect_out("cnt1", 1, 0, 1, 7);
    step(1, 1, 2'd2, 4'hE, 4'h0); expect_out("cntE", 1, 0, 0, 7);

    step(1, 1, 2'd2, 4'h1, 4'h0); expect_out("cnt2", 2, 0, 1, 7);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 2'd2, 4'h1, 4'h0); expect_out("en_off", 2, 0, 0, 7);
    end
    step(1, 1, 2'd2, 4'h1, 4'h0); expect_out("en_on", 3, 0, 1, 7);
    step(1, 1, 2'd0, 4'h1, 4'h0); expect_out("modehold", 3, 0, 0, 7);
    step(1, 1, 2'd2, 4'h1, 4'h0); expect_out("resume", 4, 0, 1, 7);

    for (int i = 0; i < 10; i++) begin
      step(1, 1, 2'd1, 4'h1, 4'h0);
    end
    expect_out("sat", 4, 0, 1, 7);
    step(1, 1, 2'd3, 4'h0, 4'h4); expect_out("loadsame", 4, 0, 0, 7);

    step(1, 1, 2'd3, 4'h0, 4'hF); expect_out("loadF", 15, 0, 1, 7);
    step(0, 1, 2'd2, 4'h1, 4'h0); expect_out("midrst", 0, 0, 0, 0);
    step(1, 1, 2'd2, 4'h1, 4'h0); expect_out("restart", 1, 0, 1, 1);

    // Random traffic, checked every cycle by the model compare.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 4) != 0),
           2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
